// File: rtl/hld_rd_port_arbiter_if.sv
// Request/response bus between the AFU read clients, the port arbiter and the rd_req/rd_resp FIFO pair.
// slave is the arbiter's view; master is the surrounding logic driving clients and the FIFOs.
interface hld_rd_port_arbiter_if #(
   parameter int NPORTS = 4
);
   logic [NPORTS-1:0]    cl_req_valid;
   logic [NPORTS*80-1:0] cl_req_data;
   logic [NPORTS-1:0]    cl_req_ready;
   logic [NPORTS-1:0]    cl_resp_valid;
   logic [527:0]         cl_resp_data;
   logic                 rd_req_valid;
   logic [79:0]          rd_req_data;
   logic                 rd_req_ready;
   logic                 rd_resp_valid;
   logic [527:0]         rd_resp_data;
   logic                 rd_resp_ready;

   modport slave (
      input  cl_req_valid, cl_req_data, rd_req_ready, rd_resp_valid, rd_resp_data,
      output cl_req_ready, cl_resp_valid, cl_resp_data, rd_req_valid, rd_req_data, rd_resp_ready
   );

   modport master (
      output cl_req_valid, cl_req_data, rd_req_ready, rd_resp_valid, rd_resp_data,
      input  cl_req_ready, cl_resp_valid, cl_resp_data, rd_req_valid, rd_req_data, rd_resp_ready
   );
endinterface

// File: rtl/hld_rd_port_arbiter.sv
// Round-robin merge of NPORTS read requesters onto one rd_req/rd_resp channel, 1-cycle latency both ways; optional HLD_RD_ARB_STATS_EN counters.
// rd_req_ready low holds the output register and blocks new grants; responses are never back-pressured.
module hld_rd_port_arbiter #(
   parameter int NPORTS       = 4,
   parameter int PW           = 2,
   parameter int REQ_TAG_MSB  = 79,
   parameter int RESP_TAG_MSB = 527,
   parameter int MAX_OUT      = 32
) (
   input  logic                  a_clk,
   input  logic                  rst,
   hld_rd_port_arbiter_if.slave  bus,
   output logic                  idle,
   output logic                  err
`ifdef HLD_RD_ARB_STATS_EN
   ,
   output logic [NPORTS*32-1:0]  stat_grants,
   output logic [NPORTS*32-1:0]  stat_stalls
`endif
);

   localparam int            CW        = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

   // registered state
   logic [PW-1:0]     rr_ptr;
   logic [CW-1:0]     out_cnt [NPORTS];
   logic              rd_req_valid_q;
   logic [79:0]       rd_req_data_q;
   logic [NPORTS-1:0] cl_resp_valid_q;
   logic [527:0]      cl_resp_data_q;
   logic              err_q;
   logic              idle_q;

   // combinational
   logic              out_free;
   logic [NPORTS-1:0] eligible;
   logic [NPORTS-1:0] grant;
   logic              grant_any;
   logic [PW-1:0]     grant_idx;
   logic [PW-1:0]     ptr_nxt;
   logic [79:0]       req_word;
   logic [PW-1:0]     resp_p;
   logic              resp_ok;
   logic [527:0]      resp_word;
   logic [NPORTS-1:0] dec;
   logic [CW-1:0]     cnt_nxt [NPORTS];
   logic              cnt_zero;
   logic              req_vld_nxt;
   logic              idle_nxt;

   always_comb begin
      out_free = !rd_req_valid_q || bus.rd_req_ready;
      for (int i = 0; i < NPORTS; i++) begin
         eligible[i] = bus.cl_req_valid[i] && (out_cnt[i] < MAX_OUT_C);
      end
   end

   // Search starts at rr_ptr and wraps; no grant is offered while in reset.
   always_comb begin : grant_sel
      int idx;
      idx       = 0;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      req_word  = '0;
      for (int k = 0; k < NPORTS; k++) begin
         idx = (int'(rr_ptr) + k) % NPORTS;
         if (!grant_any && rst && out_free && eligible[idx]) begin
            grant_any  = 1'b1;
            grant_idx  = PW'(idx);
            grant[idx] = 1'b1;
            req_word   = bus.cl_req_data[idx*80 +: 80];
         end
      end
      req_word[REQ_TAG_MSB -: PW] = grant_idx;
   end

   always_comb begin
      ptr_nxt = (int'(grant_idx) == NPORTS - 1) ? '0 : grant_idx + PW'(1);
   end

   // A response is only delivered for a known port that has something outstanding.
   always_comb begin
      resp_p    = bus.rd_resp_data[RESP_TAG_MSB -: PW];
      resp_ok   = 1'b0;
      if (bus.rd_resp_valid && (int'(resp_p) < NPORTS)) begin
         resp_ok = (out_cnt[resp_p] != '0);
      end
      resp_word = bus.rd_resp_data;
      resp_word[RESP_TAG_MSB -: PW] = '0;
      for (int i = 0; i < NPORTS; i++) begin
         dec[i] = resp_ok && (int'(resp_p) == i);
      end
   end

   // Accept and response on the same port in one cycle cancel out.
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         case ({grant[i], dec[i]})
            2'b10:   cnt_nxt[i] = out_cnt[i] + CW'(1);
            2'b01:   cnt_nxt[i] = out_cnt[i] - CW'(1);
            default: cnt_nxt[i] = out_cnt[i];
         endcase
      end
   end

   // idle is computed from next-state values so it lines up with the registered outputs.
   always_comb begin
      cnt_zero = 1'b1;
      for (int i = 0; i < NPORTS; i++) begin
         if (cnt_nxt[i] != '0) cnt_zero = 1'b0;
      end
      req_vld_nxt = out_free ? grant_any : rd_req_valid_q;
      idle_nxt    = cnt_zero && !req_vld_nxt && !resp_ok;
   end

   always_ff @(posedge a_clk) begin
      if (!rst) begin
         rr_ptr          <= '0;
         rd_req_valid_q  <= 1'b0;
         rd_req_data_q   <= '0;
         cl_resp_valid_q <= '0;
         cl_resp_data_q  <= '0;
         err_q           <= 1'b0;
         idle_q          <= 1'b1;
         for (int i = 0; i < NPORTS; i++) begin
            out_cnt[i] <= '0;
         end
      end else begin
         if (out_free) begin
            rd_req_valid_q <= grant_any;
            if (grant_any) rd_req_data_q <= req_word;
         end
         if (grant_any) rr_ptr <= ptr_nxt;
         cl_resp_valid_q <= dec;
         if (bus.rd_resp_valid) cl_resp_data_q <= resp_word;
         err_q  <= err_q || (bus.rd_resp_valid && !resp_ok);
         idle_q <= idle_nxt;
         for (int i = 0; i < NPORTS; i++) begin
            out_cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign bus.cl_req_ready  = grant;
   assign bus.rd_req_valid  = rd_req_valid_q;
   assign bus.rd_req_data   = rd_req_data_q;
   assign bus.cl_resp_valid = cl_resp_valid_q;
   assign bus.cl_resp_data  = cl_resp_data_q;
   assign bus.rd_resp_ready = 1'b1;
   assign idle              = idle_q;
   assign err               = err_q;

`ifdef HLD_RD_ARB_STATS_EN
   logic [31:0] grant_cnt [NPORTS];
   logic [31:0] stall_cnt [NPORTS];

   always_ff @(posedge a_clk) begin
      if (!rst) begin
         for (int i = 0; i < NPORTS; i++) begin
            grant_cnt[i] <= '0;
            stall_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
            if (bus.cl_req_valid[i] && !grant[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         stat_grants[i*32 +: 32] = grant_cnt[i];
         stat_stalls[i*32 +: 32] = stall_cnt[i];
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hld_rd_port_arbiter.sv
// Directed table-driven bench for hld_rd_port_arbiter (NPORTS=4, MAX_OUT=4).
// Inputs change on the falling edge; cl_req_ready is checked before the rising edge, registered outputs 1ns after it.
module tb_hld_rd_port_arbiter;

   logic a_clk;
   logic rst;
   logic idle;
   logic err;
`ifdef HLD_RD_ARB_STATS_EN
   logic [127:0] stat_grants;
   logic [127:0] stat_stalls;
`endif

   hld_rd_port_arbiter_if #(.NPORTS(4)) bus ();

   hld_rd_port_arbiter #(
      .NPORTS(4), .PW(2), .REQ_TAG_MSB(79), .RESP_TAG_MSB(527), .MAX_OUT(4)
   ) dut (
      .a_clk (a_clk),
      .rst   (rst),
      .bus   (bus),
      .idle  (idle),
      .err   (err)
`ifdef HLD_RD_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_stalls (stat_stalls)
`endif
   );

   initial begin
      a_clk = 1'b0;
      forever #5 a_clk = ~a_clk;
   end

   typedef struct {
      logic       rst;
      logic [3:0] vld;
      logic       rdy;
      logic       rv;
      logic [1:0] rtag;
      logic [3:0] e_rdy;
      logic       e_rv;
      logic [1:0] e_tag;
      logic [3:0] e_crv;
      logic       e_idle;
      logic       e_err;
   } vec_t;

   vec_t         tbl[$];
   int           n_chk;
   int           n_pass;
   int           cur;
   logic [525:0] resp_pat;

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rd, input logic rv,
                               input logic [1:0] rt, input logic [3:0] er, input logic erv,
                               input logic [1:0] et, input logic [3:0] ec, input logic ei, input logic ee);
      vec_t x;
      x.rst = r;  x.vld = v;  x.rdy = rd;  x.rv = rv;  x.rtag = rt;
      x.e_rdy = er;  x.e_rv = erv;  x.e_tag = et;  x.e_crv = ec;  x.e_idle = ei;  x.e_err = ee;
      return x;
   endfunction

   // Client word as driven on port i: index field deliberately 2'b11.
   function automatic logic [79:0] req_in(input int i);
      return {2'b11, 14'h1234, 48'hFEED_CAFE_BEEF, 16'(i)};
   endfunction

   function automatic logic [79:0] req_out(input logic [1:0] g);
      return {g, 14'h1234, 48'hFEED_CAFE_BEEF, 14'h0, g};
   endfunction

   task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, cur, act, exp);
   endtask

   task automatic apply(input vec_t v);
      @(negedge a_clk);
      rst               = v.rst;
      bus.cl_req_valid  = v.vld;
      bus.rd_req_ready  = v.rdy;
      bus.rd_resp_valid = v.rv;
      bus.rd_resp_data  = {v.rtag, resp_pat};
      #2;
      chk("cl_req_ready", 528'(bus.cl_req_ready), 528'(v.e_rdy));
      @(posedge a_clk);
      #1;
      chk("rd_req_valid", 528'(bus.rd_req_valid), 528'(v.e_rv));
      if (v.e_rv) chk("rd_req_data", 528'(bus.rd_req_data), 528'(req_out(v.e_tag)));
      chk("cl_resp_valid", 528'(bus.cl_resp_valid), 528'(v.e_crv));
      if (v.e_crv != 4'b0000) chk("cl_resp_data", bus.cl_resp_data, {2'b00, resp_pat});
      chk("idle", 528'(idle), 528'(v.e_idle));
      chk("err", 528'(err), 528'(v.e_err));
      chk("rd_resp_ready", 528'(bus.rd_resp_ready), 528'(1'b1));
      cur++;
   endtask

   initial begin
      logic [575:0] pat_src;
      n_chk  = 0;
      n_pass = 0;
      cur    = 0;
      pat_src  = {9{64'hA5A5_0F0F_1234_5678}};
      resp_pat = pat_src[525:0];
      rst               = 1'b0;
      bus.cl_req_valid  = '0;
      bus.rd_req_ready  = 1'b1;
      bus.rd_resp_valid = 1'b0;
      bus.rd_resp_data  = '0;
      for (int i = 0; i < 4; i++) bus.cl_req_data[i*80 +: 80] = req_in(i);

      //          rst   vld      rdy   rv    rtag   e_rdy    e_rv  e_tag  e_crv    idle  err
      // reset, ready gated while in reset
      tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
      // fairness 0,1,2,3,0
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
      // back-pressure: port 2 accepted, then held for 5 cycles of rd_req_ready=0
      tbl.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
      // routing (outstanding 2,1,2,1), then error on drained port 2
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1));
      // accept and response on port 0 in the same cycle
      tbl.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1));
      // reset clears err; credit limit on port 1
      tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
      // reset with 3 outstanding; a later response is an error
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1));

      foreach (tbl[i]) apply(tbl[i]);

      // Hand sequence: ports 1 and 3 contend, pointer must alternate between them.
      apply(mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
      for (int c = 0; c < 6; c++) begin
         apply(mk(1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, (c % 2 == 0) ? 4'b0010 : 4'b1000,
                  1'b1, (c % 2 == 0) ? 2'd1 : 2'd3, 4'b0000, 1'b0, 1'b0));
      end

      // Hand sequence: stall with two ports waiting, release grants port 0 next (pointer wrapped).
      apply(mk(1'b1, 4'b1001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0));
      apply(mk(1'b1, 4'b1001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0));
      apply(mk(1'b1, 4'b1001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0));
      apply(mk(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
